mux_tree_pipe_n: RTL and testbench

Parametrised, pipelined M-to-1 multiplexer tree with a valid/ready handshake. It generalises the fixed 64-to-1 selector to any power-of-two input count. Configurable pipeline registers are inserted between radix-2 levels so wide selectors close timing in the datapath. The unconsumed select bits travel with the data, so a new selection can be accepted every cycle. The whole pipe stalls under backpressure.

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux2to1_n.sv | 13 +
 rtl/mux_tree_level_n.sv | 23 ++
 rtl/mux_tree_pipe_n.sv | 98 +++++++++
 tb/tb_mux_tree_pipe_n.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared elaboration helpers for the pipelined multiplexer tree.
// Decides rank count and which radix-2 levels are followed by a register.
package mux_pkg;

   function automatic int unsigned n_ranks(input int unsigned addr, input int unsigned lpr);
      return (addr + lpr - 1) / lpr;
   endfunction

   // The last level is always registered so data_o comes straight from a flop.
   function automatic bit is_reg_level(input int unsigned k, input int unsigned lpr,
                                       input int unsigned addr);
      return (((k + 1) % lpr) == 0) || (k == addr - 1);
   endfunction

   function automatic bit m_matches_addr(input int unsigned m, input int unsigned addr);
      return m == (32'd1 << addr);
   endfunction

endpackage

// File: rtl/mux2to1_n.sv
// N-bit two-input multiplexer; i_sel=1 picks i_b.
module mux2to1_n #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_sel,
   output logic [N-1:0] o_y
);

   assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux_tree_level_n.sv
// One combinational radix-2 tree level: CNT candidates in, CNT/2 out.
// Output j = i_sel ? i_cand[2j+1] : i_cand[2j].
module mux_tree_level_n #(
   parameter int unsigned N   = 4,
   parameter int unsigned CNT = 2
) (
   input  logic [CNT-1:0][N-1:0]   i_cand,
   input  logic                    i_sel,
   output logic [CNT/2-1:0][N-1:0] o_cand
);

   for (genvar j = 0; j < CNT / 2; j++) begin : g_pair
      mux2to1_n #(
         .N(N)
      ) u_mux (
         .i_a  (i_cand[2*j]),
         .i_b  (i_cand[2*j+1]),
         .i_sel(i_sel),
         .o_y  (o_cand[j])
      );
   end

endmodule

// File: rtl/mux_tree_pipe_n.sv
// Pipelined M-to-1 multiplexer tree with valid/ready handshake and global stall.
// Unused select bits travel with the data so a new selection is accepted every cycle.
module mux_tree_pipe_n
   import mux_pkg::*;
#(
   parameter int unsigned N           = 4,
   parameter int unsigned ADDR        = 6,
   parameter int unsigned M           = 2 ** ADDR,
   parameter int unsigned LVL_PER_REG = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N-1:0]    data_i [M],
   input  logic [ADDR-1:0] sel,
   input  logic            valid_i,
   output logic            ready_o,
   output logic [N-1:0]    data_o,
   output logic            valid_o,
   input  logic            ready_i
);

   localparam int unsigned W = M * N;

   if (!m_matches_addr(M, ADDR)) begin : g_bad_m
      $error("mux_tree_pipe_n: M must equal 2**ADDR");
   end
   if (LVL_PER_REG < 1 || LVL_PER_REG > ADDR) begin : g_bad_lpr
      $error("mux_tree_pipe_n: LVL_PER_REG must lie in 1..ADDR");
   end

   // Index k holds the inputs of level k; candidates are packed at the low end.
   logic [M-1:0][N-1:0] w_cand [ADDR+1];
   logic [ADDR-1:0]     w_sel  [ADDR+1];
   logic                w_vld  [ADDR+1];
   logic                w_advance;

   for (genvar i = 0; i < M; i++) begin : g_in
      assign w_cand[0][i] = data_i[i];
   end
   assign w_sel[0] = sel;
   assign w_vld[0] = valid_i;

   assign w_advance = ready_i || !w_vld[ADDR];
   assign ready_o   = w_advance;
   assign valid_o   = w_vld[ADDR];
   assign data_o    = w_vld[ADDR] ? w_cand[ADDR][0] : '0;

   for (genvar k = 0; k < ADDR; k++) begin : g_lvl
      localparam int unsigned Cnt  = M >> k;
      localparam int unsigned Half = Cnt / 2;

      logic [Half-1:0][N-1:0] w_out;

      mux_tree_level_n #(
         .N  (N),
         .CNT(Cnt)
      ) u_level (
         .i_cand(w_cand[k][Cnt-1:0]),
         .i_sel (w_sel[k][0]),
         .o_cand(w_out)
      );

      if (k > 0) begin : g_hi
         logic w_unused_hi;
         assign w_unused_hi = ^w_cand[k][M-1:Cnt];
      end

      if (is_reg_level(k, LVL_PER_REG, ADDR)) begin : g_reg
         logic [Half-1:0][N-1:0] r_cand;
         logic [ADDR-1:0]        r_sel;
         logic                   r_vld;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               r_cand <= '0;
               r_sel  <= '0;
               r_vld  <= 1'b0;
            end else if (w_advance) begin
               r_cand <= w_out;
               r_sel  <= w_sel[k] >> 1;
               r_vld  <= w_vld[k];
            end
         end

         assign w_cand[k+1] = W'(r_cand);
         assign w_sel[k+1]  = r_sel;
         assign w_vld[k+1]  = r_vld;
      end else begin : g_comb
         assign w_cand[k+1] = W'(w_out);
         assign w_sel[k+1]  = w_sel[k] >> 1;
         assign w_vld[k+1]  = w_vld[k];
      end
   end

   logic w_unused_tail;
   assign w_unused_tail = ^{w_cand[ADDR][M-1:1], w_sel[ADDR]};

endmodule

// File: tb/tb_mux_tree_pipe_n.sv
// Bench for mux_tree_pipe_n: three instances (LVL_PER_REG = 2, 1, 6) share stimulus;
// directed table/sequence checks plus randomized traffic against per-instance FIFO models.
module tb_mux_tree_pipe_n;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] data_i [64];
   logic [5:0] sel;
   logic       valid_i;
   logic       ready_i;
   logic       ro [3];
   logic       vo [3];
   logic [3:0] dout [3];

   int n_chk  = 0;
   int n_pass = 0;
   int exp_lat [3] = '{3, 6, 1};

   typedef struct {
      logic [5:0] sel;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs [8];

   // Per-instance reference FIFO of words accepted but not yet delivered.
   logic [3:0] fifo [3][64];
   int         wp [3];
   int         rp [3];

   always #5 clk = ~clk;

   mux_tree_pipe_n #(
      .N(4), .ADDR(6), .M(64), .LVL_PER_REG(2)
   ) u_dut (
      .clk_i(clk), .rst_i(rst), .data_i(data_i), .sel(sel), .valid_i(valid_i),
      .ready_o(ro[0]), .data_o(dout[0]), .valid_o(vo[0]), .ready_i(ready_i)
   );

   mux_tree_pipe_n #(
      .N(4), .ADDR(6), .M(64), .LVL_PER_REG(1)
   ) u_dut_l1 (
      .clk_i(clk), .rst_i(rst), .data_i(data_i), .sel(sel), .valid_i(valid_i),
      .ready_o(ro[1]), .data_o(dout[1]), .valid_o(vo[1]), .ready_i(ready_i)
   );

   mux_tree_pipe_n #(
      .N(4), .ADDR(6), .M(64), .LVL_PER_REG(6)
   ) u_dut_l6 (
      .clk_i(clk), .rst_i(rst), .data_i(data_i), .sel(sel), .valid_i(valid_i),
      .ready_o(ro[2]), .data_o(dout[2]), .valid_o(vo[2]), .ready_i(ready_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ramp_data();
      for (int i = 0; i < 64; i++) data_i[i] = 4'(i);
   endtask

   task automatic scramble_data();
      for (int i = 0; i < 64; i++) data_i[i] = 4'($urandom);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b1;
      sel     = '0;
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   // One-cycle pulse; every instance must emit exactly one word after its own latency.
   task automatic pulse(input logic [5:0] s, input logic [3:0] e);
      int lat [3];
      int hi [3];
      for (int d = 0; d < 3; d++) begin
         lat[d] = -1;
         hi[d]  = 0;
      end
      ready_i = 1'b1;
      sel     = s;
      valid_i = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         valid_i = 1'b0;
         for (int d = 0; d < 3; d++) begin
            if (vo[d]) begin
               hi[d]++;
               if (lat[d] < 0) begin
                  lat[d] = c;
                  chk("pulse_data", 32'(dout[d]), 32'(e));
               end
            end
         end
      end
      for (int d = 0; d < 3; d++) begin
         chk("pulse_latency", lat[d], exp_lat[d]);
         chk("pulse_single_beat", hi[d], 1);
      end
   endtask

   initial begin
      logic [5:0] bb_sel [4];
      logic [3:0] bb_exp [4];
      logic [3:0] stall_exp [4];
      logic [3:0] ref_word;
      int         hi_cnt;

      vecs[0] = '{sel: 6'd37, exp: 4'h5};
      vecs[1] = '{sel: 6'd0,  exp: 4'h0};
      vecs[2] = '{sel: 6'd63, exp: 4'hF};
      vecs[3] = '{sel: 6'd1,  exp: 4'h1};
      vecs[4] = '{sel: 6'd62, exp: 4'hE};
      vecs[5] = '{sel: 6'd15, exp: 4'hF};
      vecs[6] = '{sel: 6'd16, exp: 4'h0};
      vecs[7] = '{sel: 6'd42, exp: 4'hA};
      bb_sel    = '{6'd0, 6'd63, 6'd1, 6'd62};
      bb_exp    = '{4'h0, 4'hF, 4'h1, 4'hE};
      stall_exp = '{4'hA, 4'hB, 4'hC, 4'hD};

      valid_i = 1'b0;
      ready_i = 1'b0;
      sel     = '0;
      ramp_data();
      #1 rst = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("reset_valid_o", 32'(vo[d]), 0);
         chk("reset_data_o", 32'(dout[d]), 0);
         chk("reset_ready_o", 32'(ro[d]), 1);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();

      for (int v = 0; v < 8; v++) pulse(vecs[v].sel, vecs[v].exp);

      // Back-to-back selections emerge on consecutive cycles from cycle 3.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         if (c < 4) begin
            sel     = bb_sel[c];
            valid_i = 1'b1;
         end else begin
            valid_i = 1'b0;
         end
         if (c >= 3 && c <= 6) begin
            chk("b2b_valid", 32'(vo[0]), 1);
            chk("b2b_data", 32'(dout[0]), 32'(bb_exp[c-3]));
         end
         if (c == 7) chk("b2b_done", 32'(vo[0]), 0);
         tick();
      end

      // Backpressure: output held, input refused, then A..D without loss.
      do_reset();
      for (int c = 0; c < 3; c++) begin
         sel     = 6'(10 + c);
         valid_i = 1'b1;
         tick();
      end
      sel     = 6'd13;
      ready_i = 1'b0;
      for (int c = 3; c < 7; c++) begin
         #1;
         chk("stall_valid", 32'(vo[0]), 1);
         chk("stall_data", 32'(dout[0]), 32'hA);
         chk("stall_ready", 32'(ro[0]), 0);
         scramble_data();
         tick();
      end
      ramp_data();
      ready_i = 1'b1;
      #1;
      chk("resume_ready", 32'(ro[0]), 1);
      for (int c = 0; c < 4; c++) begin
         chk("resume_valid", 32'(vo[0]), 1);
         chk("resume_data", 32'(dout[0]), 32'(stall_exp[c]));
         tick();
         valid_i = 1'b0;
      end
      chk("resume_done", 32'(vo[0]), 0);

      // Asynchronous reset with items in flight.
      do_reset();
      for (int c = 0; c < 3; c++) begin
         sel     = 6'(20 + c);
         valid_i = 1'b1;
         tick();
      end
      valid_i = 1'b0;
      ready_i = 1'b0;
      chk("pre_reset_valid", 32'(vo[0]), 1);
      #2 rst = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("async_rst_valid", 32'(vo[d]), 0);
         chk("async_rst_data", 32'(dout[d]), 0);
         chk("async_rst_ready", 32'(ro[d]), 1);
      end
      @(negedge clk);
      rst     = 1'b0;
      ready_i = 1'b1;
      hi_cnt  = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         for (int d = 0; d < 3; d++) if (vo[d]) hi_cnt++;
      end
      chk("no_stale_output", hi_cnt, 0);
      pulse(6'd37, 4'h5);

      // Exhaustive sel sweep then random traffic against FIFO models.
      do_reset();
      for (int d = 0; d < 3; d++) begin
         wp[d] = 0;
         rp[d] = 0;
      end
      for (int cyc = 0; cyc < 10074; cyc++) begin
         scramble_data();
         if (cyc < 64) begin
            sel     = 6'(cyc);
            valid_i = 1'b1;
            ready_i = 1'b1;
         end else if (cyc < 10064) begin
            sel     = 6'($urandom);
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
         end else begin
            valid_i = 1'b0;
            ready_i = 1'b1;
         end
         #1;
         for (int d = 0; d < 3; d++) begin
            chk("ready_rule", 32'(ro[d]), 32'(ready_i || !vo[d]));
            if (!vo[d]) chk("idle_data_zero", 32'(dout[d]), 0);
            if (vo[d] && ready_i) begin
               chk("out_has_item", 32'(wp[d] > rp[d]), 1);
               if (wp[d] > rp[d]) begin
                  chk("stream_data", 32'(dout[d]), 32'(fifo[d][rp[d] % 64]));
                  rp[d]++;
               end
            end
            if (valid_i && ro[d]) begin
               ref_word = data_i[sel];
               fifo[d][wp[d] % 64] = ref_word;
               wp[d]++;
            end
         end
         tick();
      end
      for (int d = 0; d < 3; d++) chk("drain_empty", wp[d] - rp[d], 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
